// File: rtl/booth_pkg.sv
// Shared FSM state type and Booth row opcodes for the sequential multiplier.
package booth_pkg;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} booth_state_t;

  // Opcodes are {Q[0], q_m1}: the current multiplier bit and the bit shifted out before it.
  localparam logic [1:0] BOOTH_PASS = 2'b00;
  localparam logic [1:0] BOOTH_ADD  = 2'b01;
  localparam logic [1:0] BOOTH_SUB  = 2'b10;

endpackage

// File: rtl/multiplier_row.sv
// One Booth add/sub/pass row. This is the only adder in the sequential multiplier.
module multiplier_row
  import booth_pkg::*;
#(
  parameter int N = 9
) (
  input  logic [N-1:0] P_in,
  input  logic [N-1:0] M_in,
  input  logic [1:0]   Q_in,
  output logic [N-1:0] P_out,
  output logic         C_out
);

  // Select the row operation. Encoding 11 also means pass.
  always_comb begin
    {C_out, P_out} = {1'b0, P_in};
    case (Q_in)
      BOOTH_ADD: {C_out, P_out} = {1'b0, P_in} + {1'b0, M_in};
      BOOTH_SUB: {C_out, P_out} = {1'b0, P_in} + {1'b0, ~M_in} + {{N{1'b0}}, 1'b1};
      default:   {C_out, P_out} = {1'b0, P_in};
    endcase
  end

endmodule

// File: rtl/seq_booth_multiplier.sv
// Sequential radix-2 Booth multiplier. One row is reused for N iterations.
// Timing: the load happens at edge E0 and the iterations at E1..EN.
// z_out and done are registered when the FSM leaves S_DONE, at E(N+1).
module seq_booth_multiplier
  import booth_pkg::*;
#(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [N-1:0]   x_in,
  input  logic [N-1:0]   y_in,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] z_out
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  booth_state_t state, state_nxt;

  // P and M carry one extra bit so that P-M cannot overflow when M = -2^(N-1).
  logic [N:0]    p_reg, m_reg, p_row;
  logic [N-1:0]  q_reg;
  logic          q_m1;
  logic [CW-1:0] count;
  logic [1:0]    op;
  logic          row_c_unused;

  assign op = {q_reg[0], q_m1};

  multiplier_row #(.N(N + 1)) u_row (
    .P_in  (p_reg),
    .M_in  (m_reg),
    .Q_in  (op),
    .P_out (p_row),
    .C_out (row_c_unused)
  );

  // Next-state logic. A start during CALC or DONE is ignored.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_CALC;
      S_CALC:  if (count == LAST) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register. A synchronous reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Datapath: load the operands, then shift the row result right arithmetically, then publish.
  always_ff @(posedge clk) begin
    if (reset) begin
      p_reg <= '0;
      m_reg <= '0;
      q_reg <= '0;
      q_m1  <= 1'b0;
      count <= '0;
      z_out <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          m_reg <= {x_in[N-1], x_in};
          q_reg <= y_in;
          p_reg <= '0;
          q_m1  <= 1'b0;
          count <= '0;
        end
        S_CALC: begin
          p_reg <= {p_row[N], p_row[N:1]};
          q_reg <= {p_row[0], q_reg[N-1:1]};
          q_m1  <= q_reg[0];
          count <= count + 1'b1;
        end
        S_DONE: z_out <= {p_reg[N-1:0], q_reg};
        default: ;
      endcase
    end
  end

  // Registered status flags. done is high for the single cycle after S_DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_nxt != S_IDLE);
      done <= (state == S_DONE);
    end
  end

endmodule

// File: tb/tb_seq_booth_multiplier.sv
// Directed bench for seq_booth_multiplier with N=8. Outputs are sampled 1ns after each rising edge.
module tb_seq_booth_multiplier;

  localparam int N = 8;
  localparam int LAT = N + 1;

  logic           clk = 1'b0;
  logic           reset, start;
  logic [N-1:0]   x_in, y_in;
  logic           busy, done;
  logic [2*N-1:0] z_out;

  int n_chk = 0;
  int n_fail = 0;

  seq_booth_multiplier #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .x_in  (x_in),
    .y_in  (y_in),
    .busy  (busy),
    .done  (done),
    .z_out (z_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start one operation, optionally pulse start again with other operands mid-CALC,
  // wait for done (bounded), then confirm done drops after one cycle.
  task automatic run_op(input string tag, input int x, input int y, input bit inject,
                        input logic [2*N-1:0] exp);
    int lat;
    x_in = N'(x); y_in = N'(y); start = 1'b1;
    tick();
    start = 1'b0;
    x_in = 8'h55; y_in = 8'hAA;
    lat = 0;
    while (!done && lat < 30) begin
      if (inject && lat == 3) begin
        x_in = 8'd5; y_in = 8'd5; start = 1'b1;
      end
      tick();
      start = 1'b0;
      lat++;
    end
    check({tag, "_lat"}, lat, LAT);
    check({tag, "_z"}, z_out, exp);
    check({tag, "_busy"}, busy, 1'b0);
    tick();
    check({tag, "_done1"}, done, 1'b0);
    check({tag, "_hold"}, z_out, exp);
  endtask

  initial begin
    int seen;
    reset = 1'b1; start = 1'b0; x_in = '0; y_in = '0;
    tick(); tick();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_z", z_out, 16'h0000);
    reset = 1'b0;
    tick();

    run_op("t1", -48, 75, 1'b0, 16'hF1F0);
    run_op("t2a", -128, -128, 1'b0, 16'h4000);
    run_op("t2b", 127, -128, 1'b0, 16'hC080);
    run_op("t3a", 0, -1, 1'b0, 16'h0000);
    run_op("t3b", -1, -1, 1'b0, 16'h0001);
    run_op("t4a", 3, 7, 1'b1, 16'h0015);
    run_op("t4b", 5, 5, 1'b0, 16'h0019);

    // Reset during CALC discards the operation.
    x_in = 8'd7; y_in = 8'd9; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("t5_busy_pre", busy, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_busy", busy, 1'b0);
    check("t5_done", done, 1'b0);
    check("t5_z", z_out, 16'h0000);
    seen = 0;
    repeat (12) begin
      tick();
      if (done || busy) seen++;
    end
    check("t5_quiet", seen, 0);

    // Coarse sweep that includes both extremes of each operand.
    for (int i = -128; i < 128; i += 51) begin
      for (int j = -128; j < 128; j += 37) begin
        run_op("sw", i, j, 1'b0, 16'(i * j));
      end
      run_op("swmax", i, 127, 1'b0, 16'(i * 127));
    end
    run_op("swmm", 127, 127, 1'b0, 16'h3F01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
